// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU trace-line checker.
// Latency/backpressure: n/a (declarations only).
package cpu_trace_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_TIME, ST_PC, ST_COLON, ST_SP1, ST_REG,
    ST_ADDR, ST_SP2, ST_EQ, ST_SP3, ST_DATA, ST_SP4
  } state_t;

  localparam logic [1:0] FMT_NONE = 2'd0;
  localparam logic [1:0] FMT_REG  = 2'd1;
  localparam logic [1:0] FMT_MEM  = 2'd2;

  localparam int ERR_TIME = 0;
  localparam int ERR_PC   = 1;
  localparam int ERR_ADDR = 2;
  localparam int ERR_GRF  = 3;
  localparam int ERR_SEQ  = 4;

  localparam logic [7:0] CH_CARET  = 8'h5e;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3a;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2a;
  localparam logic [7:0] CH_LT     = 8'h3c;
  localparam logic [7:0] CH_EQ     = 8'h3d;
  localparam logic [7:0] CH_HASH   = 8'h23;

  // Bits needed to hold any value of the given number of decimal digits.
  function automatic int dec_width(input int digits);
    return $clog2(10 ** digits);
  endfunction

endpackage

// File: rtl/cpu_trace_checker_if.sv
// Char-stream input and parsed-record result bundle for the trace checker.
// Latency/backpressure: none; char/freq are sampled every clock, no stall.
interface cpu_trace_checker_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       char;
  logic [15:0]      freq;
  logic [1:0]       format_type;
  logic [4:0]       error_code;
  logic             rec_valid;
  logic [31:0]      rec_pc;
  logic [31:0]      rec_data;
  logic [CNT_W-1:0] rec_cnt;

  modport master (
    output char, freq,
    input  format_type, error_code, rec_valid, rec_pc, rec_data, rec_cnt
  );

  modport slave (
    input  char, freq,
    output format_type, error_code, rec_valid, rec_pc, rec_data, rec_cnt
  );
endinterface

// File: rtl/trace_char_class.sv
// Classifies one ASCII char as decimal/hex digit or space and decodes its nibble.
// Latency: combinational; no backpressure.
module trace_char_class
  import cpu_trace_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_dec,
  output logic       is_hex,
  output logic       is_space,
  output logic [3:0] nibble
);
  logic is_lc, is_uc;

  always_comb begin
    is_dec   = (ch >= 8'h30) && (ch <= 8'h39);
    is_lc    = (ch >= 8'h61) && (ch <= 8'h66);
    is_uc    = (ch >= 8'h41) && (ch <= 8'h46);
    is_hex   = is_dec || is_lc || is_uc;
    is_space = (ch == CH_SPACE);
    // 'a'/'A' have low nibble 1, so letters decode as low nibble + 9.
    nibble   = is_dec ? ch[3:0] : (ch[3:0] + 4'd9);
  end
endmodule

// File: rtl/cpu_trace_checker.sv
// Parses "^T@PC: $R|*ADDR <= DATA#" trace lines and flags semantic errors per record.
// Latency: results 1 cycle after '#' is sampled; no backpressure, one char per clock.
module cpu_trace_checker
  import cpu_trace_pkg::*;
#(
  parameter int unsigned TIME_DIGITS = 4,
  parameter int unsigned REG_DIGITS  = 4,
  parameter int unsigned NUM_REGS    = 32,
  parameter logic [31:0] PC_MIN      = 32'h0000_3000,
  parameter logic [31:0] PC_MAX      = 32'h0000_6ffc,
  parameter logic [31:0] ADDR_MAX    = 32'h0000_2ffc,
  parameter int unsigned CNT_W       = 16,
  parameter bit          SEQ_CHECK   = 1'b1
) (
  input logic               clk,
  input logic               reset,
  cpu_trace_checker_if.slave tif
);
  localparam int TIME_W = dec_width(TIME_DIGITS);
  localparam int REG_W  = dec_width(REG_DIGITS);
  localparam logic [3:0] TIME_N = 4'(TIME_DIGITS);
  localparam logic [3:0] REG_N  = 4'(REG_DIGITS);

  logic       is_dec, is_hex, is_space;
  logic [3:0] nib;
  logic [7:0] ch;

  assign ch = tif.char;

  trace_char_class u_class (
    .ch      (ch),
    .is_dec  (is_dec),
    .is_hex  (is_hex),
    .is_space(is_space),
    .nibble  (nib)
  );

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [TIME_W-1:0]   time_q, time_d;
  logic [REG_W-1:0]    reg_q, reg_d;
  logic [31:0]         pc_q, pc_d, addr_q, addr_d, data_q, data_d;
  logic                is_mem_q, is_mem_d;
  logic                done;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    time_d   = time_q;
    reg_d    = reg_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    data_d   = data_q;
    is_mem_d = is_mem_q;
    done     = 1'b0;
    if (ch == CH_CARET) begin
      state_d = ST_TIME;
      cnt_d   = '0;
      time_d  = '0;
      reg_d   = '0;
      pc_d    = '0;
      addr_d  = '0;
      data_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_TIME:
          if (is_dec && cnt_q < TIME_N) begin
            time_d = (time_q << 3) + (time_q << 1) + TIME_W'(nib);
            cnt_d  = cnt_q + 4'd1;
          end else if (ch == CH_AT && cnt_q != 4'd0) begin
            state_d = ST_PC;
            cnt_d   = '0;
          end else state_d = ST_IDLE;
        // The 8th PC digit moves on to COLON, so a 9th digit is rejected there.
        ST_PC:
          if (is_hex) begin
            pc_d  = {pc_q[27:0], nib};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) state_d = ST_COLON;
          end else state_d = ST_IDLE;
        ST_COLON: state_d = (ch == CH_COLON) ? ST_SP1 : ST_IDLE;
        ST_SP1:
          if (is_space) state_d = ST_SP1;
          else if (ch == CH_DOLLAR) begin
            state_d  = ST_REG;
            cnt_d    = '0;
            is_mem_d = 1'b0;
          end else if (ch == CH_STAR) begin
            state_d  = ST_ADDR;
            cnt_d    = '0;
            is_mem_d = 1'b1;
          end else state_d = ST_IDLE;
        ST_REG:
          if (is_dec && cnt_q < REG_N) begin
            reg_d = (reg_q << 3) + (reg_q << 1) + REG_W'(nib);
            cnt_d = cnt_q + 4'd1;
          end else if (cnt_q != 4'd0 && is_space) state_d = ST_SP2;
          else if (cnt_q != 4'd0 && ch == CH_LT)  state_d = ST_EQ;
          else state_d = ST_IDLE;
        ST_ADDR:
          if (is_hex && cnt_q < 4'd8) begin
            addr_d = {addr_q[27:0], nib};
            cnt_d  = cnt_q + 4'd1;
          end else if (cnt_q == 4'd8 && is_space) state_d = ST_SP2;
          else if (cnt_q == 4'd8 && ch == CH_LT)  state_d = ST_EQ;
          else state_d = ST_IDLE;
        ST_SP2:
          if (is_space) state_d = ST_SP2;
          else if (ch == CH_LT) state_d = ST_EQ;
          else state_d = ST_IDLE;
        ST_EQ: state_d = (ch == CH_EQ) ? ST_SP3 : ST_IDLE;
        ST_SP3:
          if (is_space) state_d = ST_SP3;
          else if (is_hex) begin
            state_d = ST_DATA;
            data_d  = {28'd0, nib};
            cnt_d   = 4'd1;
          end else state_d = ST_IDLE;
        ST_DATA:
          if (is_hex && cnt_q < 4'd8) begin
            data_d = {data_q[27:0], nib};
            cnt_d  = cnt_q + 4'd1;
          end else if (cnt_q == 4'd8 && is_space) state_d = ST_SP4;
          else if (cnt_q == 4'd8 && ch == CH_HASH) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else state_d = ST_IDLE;
        ST_SP4:
          if (is_space) state_d = ST_SP4;
          else if (ch == CH_HASH) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      time_q   <= '0;
      reg_q    <= '0;
      pc_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      is_mem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      time_q   <= time_d;
      reg_q    <= reg_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      is_mem_q <= is_mem_d;
    end
  end

  logic [14:0]      half, divisor;
  logic [4:0]       err_c;
  logic [31:0]      prev_pc_q;
  logic             prev_vld_q;
  logic [1:0]       fmt_q;
  logic [4:0]       err_q;
  logic             vld_q;
  logic [31:0]      rpc_q, rdata_q;
  logic [CNT_W-1:0] rcnt_q;
  logic             unused_freq_lsb;

  assign half            = tif.freq[15:1];
  assign unused_freq_lsb = tif.freq[0];

  // Divisor forced nonzero so '%' never sees zero; a zero half-period is flagged directly.
  always_comb begin
    err_c    = '0;
    divisor  = (half == 15'd0) ? 15'd1 : half;
    err_c[ERR_TIME] = (half == 15'd0) || ((32'(time_q) % 32'(divisor)) != 32'd0);
    err_c[ERR_PC]   = (pc_q < PC_MIN) || (pc_q > PC_MAX) || (pc_q[1:0] != 2'b00);
    err_c[ERR_ADDR] = is_mem_q && ((addr_q > ADDR_MAX) || (addr_q[1:0] != 2'b00));
    err_c[ERR_GRF]  = !is_mem_q && (32'(reg_q) >= NUM_REGS);
    err_c[ERR_SEQ]  = SEQ_CHECK && prev_vld_q && (pc_q != prev_pc_q + 32'd4);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fmt_q      <= FMT_NONE;
      err_q      <= '0;
      vld_q      <= 1'b0;
      rpc_q      <= '0;
      rdata_q    <= '0;
      rcnt_q     <= '0;
      prev_pc_q  <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      vld_q <= done;
      if (done) begin
        fmt_q      <= is_mem_q ? FMT_MEM : FMT_REG;
        err_q      <= err_c;
        rpc_q      <= pc_q;
        rdata_q    <= data_q;
        prev_pc_q  <= pc_q;
        prev_vld_q <= 1'b1;
        if (rcnt_q != '1) rcnt_q <= rcnt_q + 1'b1;
      end else begin
        fmt_q <= FMT_NONE;
        err_q <= '0;
      end
    end
  end

  assign tif.format_type = fmt_q;
  assign tif.error_code  = err_q;
  assign tif.rec_valid   = vld_q;
  assign tif.rec_pc      = rpc_q;
  assign tif.rec_data    = rdata_q;
  assign tif.rec_cnt     = rcnt_q;
endmodule

// File: tb/tb_cpu_trace_checker.sv
// Directed self-checking bench for cpu_trace_checker.
module tb_cpu_trace_checker;
  import cpu_trace_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  cpu_trace_checker_if #(.CNT_W(16)) tif ();

  cpu_trace_checker #(.CNT_W(16)) dut (
    .clk  (clk),
    .reset(reset),
    .tif  (tif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      tif.char = s[i];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    tif.char = 8'h0a;
    @(posedge clk);
    #1;
  endtask

  task automatic check_rec(input string tag, input logic [1:0] fmt, input logic [4:0] err,
                           input logic [31:0] pc, input logic [31:0] data, input int cnt);
    chk({tag, "_fmt"},   32'(tif.format_type), 32'(fmt));
    chk({tag, "_err"},   32'(tif.error_code),  32'(err));
    chk({tag, "_vld"},   32'(tif.rec_valid),   32'd1);
    chk({tag, "_pc"},    tif.rec_pc,           pc);
    chk({tag, "_data"},  tif.rec_data,         data);
    chk({tag, "_cnt"},   32'(tif.rec_cnt),     32'(cnt));
  endtask

  string bad[5];

  initial begin
    bad[0] = "^2@000030f4: $3 <=1234567#";
    bad[1] = "^2@000030f4: $3 <=1234567890#";
    bad[2] = "^2ab@000030f4: $3 <=12345678#";
    bad[3] = "^2@000030f4: $3 <=#";
    bad[4] = "##";

    reset    = 1'b1;
    tif.char = 8'h0a;
    tif.freq = 16'd4;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fmt",  32'(tif.format_type), 32'd0);
    chk("rst_err",  32'(tif.error_code),  32'd0);
    chk("rst_vld",  32'(tif.rec_valid),   32'd0);
    chk("rst_pc",   tif.rec_pc,           32'd0);
    chk("rst_data", tif.rec_data,         32'd0);
    chk("rst_cnt",  32'(tif.rec_cnt),     32'd0);
    reset = 1'b0;

    send("^2@000030f4: $3 <=12345678#");
    check_rec("reg1", FMT_REG, 5'h00, 32'h30f4, 32'h1234_5678, 1);
    idle();
    chk("reg1_clr_fmt", 32'(tif.format_type), 32'd0);
    chk("reg1_clr_vld", 32'(tif.rec_valid),   32'd0);
    chk("reg1_hold_pc", tif.rec_pc,           32'h30f4);

    reset = 1'b1;
    idle();
    reset = 1'b0;
    send("^338@00003130: *00000088 <= Ffffb528#");
    check_rec("mem1", FMT_MEM, 5'h00, 32'h3130, 32'hffff_b528, 1);

    // Half-period 4: time 338 fails; repeated PC also breaks the +4 sequence.
    tif.freq = 16'd8;
    idle();
    send("^338@00003130: *00000088 <= Ffffb528#");
    check_rec("mem_f8", FMT_MEM, 5'h11, 32'h3130, 32'hffff_b528, 2);
    send("^2@00003131: $32 <=00000000#");
    check_rec("reg_bad", FMT_REG, 5'h1b, 32'h3131, 32'h0, 3);

    tif.freq = 16'd4;
    for (int k = 0; k < 5; k++) begin
      send(bad[k]);
      chk($sformatf("bad%0d_fmt", k), 32'(tif.format_type), 32'd0);
      chk($sformatf("bad%0d_cnt", k), 32'(tif.rec_cnt),     32'd3);
      idle();
    end

    send("^10@00005000: *00002ffc <= 0000abcd #");
    check_rec("recover", FMT_MEM, 5'h10, 32'h5000, 32'h0000_abcd, 4);

    send("^2@00005004: $31 <=00000001#");
    check_rec("b2b_a", FMT_REG, 5'h00, 32'h5004, 32'h1, 5);
    send("^2@00005008:$0<=00000002#");
    check_rec("b2b_b", FMT_REG, 5'h00, 32'h5008, 32'h2, 6);

    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("rst2_cnt", 32'(tif.rec_cnt), 32'd0);
    send("^242@000030f4: $3");
    reset    = 1'b1;
    tif.char = 8'h20;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(" <=12345678#");
    chk("abort_fmt", 32'(tif.format_type), 32'd0);
    chk("abort_vld", 32'(tif.rec_valid),   32'd0);
    chk("abort_cnt", 32'(tif.rec_cnt),     32'd0);

    send("^2@00003000: $3 <=00000011#");
    check_rec("seq1", FMT_REG, 5'h00, 32'h3000, 32'h11, 1);
    send("^4@00003004: $4 <=00000022#");
    check_rec("seq2", FMT_REG, 5'h00, 32'h3004, 32'h22, 2);
    send("^6@0000300c: $5 <=00000033#");
    check_rec("seq3", FMT_REG, 5'h10, 32'h300c, 32'h33, 3);

    tif.freq = 16'd1;
    send("^2@00007000: *00003000 <=00000000#");
    check_rec("bounds_hi", FMT_MEM, 5'h17, 32'h7000, 32'h0, 4);
    tif.freq = 16'd4;
    send("^2@00002ffc: $0 <=00000000#");
    check_rec("pc_lo", FMT_REG, 5'h12, 32'h2ffc, 32'h0, 5);
    send("^2@00006ffc: *00000002 <=00000000#");
    check_rec("addr_unal", FMT_MEM, 5'h14, 32'h6ffc, 32'h0, 6);
    idle();
    chk("end_vld", 32'(tif.rec_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
